bp_update_sched: RTL and testbench
==================================

BP_UPDATE_SCHED -- requirements
Module: bp_update_sched

Interface
REQ-001 SHALL have one clock and one reset: reset is synchronous and active-low.
REQ-002 SHALL have port CLK  in  1  clock; all state changes on the rising edge.
REQ-003 SHALL have port nRST  in  1  synchronous active-low reset, sampled on the CLK rising edge.
REQ-004 SHALL have port upd_valid  in  1  resolved BEQ/BNE in the MEM stage.
REQ-005 SHALL have port upd_pc  in  32  PC of the resolved branch.
REQ-006 SHALL have port upd_target  in  32  resolved branch address.
REQ-007 SHALL have port upd_mispredict  in  1  the prediction was wrong.
REQ-008 SHALL have port upd_ready  out  1  the update queue can accept an update.
REQ-009 SHALL have port flush_req  in  1  request to invalidate the whole predictor/BTB.
REQ-010 SHALL have port flush_busy  out  1  an invalidation sweep is in progress.
REQ-011 SHALL have port tbl_we  out  1  table write strobe to the predictor.
REQ-012 SHALL have port tbl_idx  out  8  table index (PC[9:2]).
REQ-013 SHALL have port tbl_target  out  32  BTB write data.
REQ-014 SHALL have port tbl_mispredict  out  1  advance the 2-bit counter on a mispredict.
REQ-015 SHALL have port tbl_clear  out  1  reset the entry: counter=00, BTB=0.

Function
REQ-016 SHALL contain a 4-entry FIFO of {idx, target, mispredict}.
- upd_ready = FIFO not full.
- An update SHALL be pushed when upd_valid && upd_ready && !flush_req.
- upd_valid while the FIFO is full: the update is dropped, FIFO unchanged.
REQ-017 SHALL implement FSM states SWEEP and RUN.
REQ-018 In RUN with the FIFO non-empty:
- tbl_we=1, tbl_clear=0, tbl_* = FIFO head.
- The head is popped on that edge.
- Maximum one write per cycle.
REQ-019 Timing in RUN: an update accepted at edge k into an empty FIFO SHALL appear on tbl_* during the cycle after edge k and be retired at edge k+1.
REQ-020 A simultaneous push and pop SHALL keep the occupancy unchanged and preserve FIFO order.
REQ-021 In SWEEP:
- tbl_we=1, tbl_clear=1, tbl_target=0, tbl_mispredict=0, flush_busy=1.
- tbl_idx = sweep counter; the counter increments every cycle.
- Leave for RUN after idx 255 is written: 256 cycles total.
- The FIFO SHALL accept but not issue during SWEEP.
REQ-022 Handling of flush_req:
- In RUN: the FIFO is cleared, the counter is set to 0, and the FSM enters SWEEP on the next edge.
- In SWEEP: the counter restarts at 0 and the FIFO is cleared.
REQ-023 With flush_req and upd_valid in the same cycle, the flush SHALL win and the update SHALL be discarded.
REQ-024 In RUN with the FIFO empty: tbl_we=0, and tbl_idx, tbl_target, tbl_mispredict and tbl_clear SHALL all be 0.
REQ-025 The FIFO pointers SHALL be 2 bits with wrap-around; an occupancy counter of 0..4 SHALL distinguish full from empty.

Reset
REQ-026 When nRST=0 at a rising edge, the FSM SHALL go to SWEEP with counter=0 and the FIFO empty.
REQ-027 A reset during RUN or SWEEP SHALL abort the operation in progress and discard queued updates.
REQ-028 Outputs in the cycle after reset SHALL be:
- upd_ready=1.
- flush_busy=1.
- tbl_we=1, tbl_clear=1, tbl_idx=0, tbl_target=0, tbl_mispredict=0.

Configuration
REQ-029 Macro BP_UPD_STATS_EN defined:
- Adds outputs stat_upd (16-bit), stat_misp (16-bit) and stat_drop (16-bit).
- These are saturating counts of retired updates, retired mispredicts and dropped updates.
- All are cleared by reset; flush does not clear them.
REQ-030 Macro BP_UPD_STATS_EN undefined: these ports and counters SHALL be absent, with the behaviour otherwise identical.

Verification
REQ-031 Reset, then idle 256 cycles -> tbl_we=1 and tbl_clear=1 with tbl_idx 0..255 in order, then flush_busy=0 and tbl_we=0.
REQ-032 RUN, push pc=0x0000_0104, target=0x0000_0200, mispredict=1 -> next cycle tbl_we=1, idx=0x41, target=0x200, mispredict=1; the following cycle tbl_we=0.
REQ-033 Six updates at consecutive edges during SWEEP -> first four accepted, upd_ready=0 for the last two (dropped), four writes in order after SWEEP ends; with stats, stat_drop=2.
REQ-034 flush_req at sweep idx 100 -> the idx sequence restarts at 0 and SWEEP lasts 256 further cycles.
REQ-035 flush_req with upd_valid while 2 entries are queued in SWEEP -> FIFO empty, no update writes after the sweep.
REQ-036 nRST=0 for one cycle in RUN with 3 queued -> SWEEP restarts at idx 0, and no queued updates are issued.

Source files
------------

// File: rtl/bp_update_sched.sv
// bp_update_sched: queues resolved-branch updates from MEM into a 4-deep FIFO
// and retires them into the predictor/BTB tables at one write per cycle.
// Reset and flush run a full 256-entry invalidation sweep first.
// The sweep writes counter=00 and BTB=0 into every entry.
// Optional build macro: BP_UPD_STATS_EN. It adds saturating counters for
// retired updates (stat_upd), retired mispredicts (stat_misp) and dropped
// updates (stat_drop).
// Handshake: an update is taken on a rising edge when upd_valid && upd_ready
// && !flush_req. upd_valid while upd_ready=0 drops the update; it is not held.
// dbg_state exposes the FSM state: 0 = SWEEP, 1 = RUN.
module bp_update_sched (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic [31:0] upd_target,
   input  logic        upd_mispredict,
   output logic        upd_ready,
   input  logic        flush_req,
   output logic        flush_busy,
   output logic        tbl_we,
   output logic [7:0]  tbl_idx,
   output logic [31:0] tbl_target,
   output logic        tbl_mispredict,
   output logic        tbl_clear,
   output logic        dbg_state
`ifdef BP_UPD_STATS_EN
   ,
   output logic [15:0] stat_upd,
   output logic [15:0] stat_misp,
   output logic [15:0] stat_drop
`endif
);

   typedef enum logic {
      ST_SWEEP = 1'b0,
      ST_RUN   = 1'b1
   } state_e;

   typedef struct packed {
      logic [7:0]  idx;
      logic [31:0] target;
      logic        mispredict;
   } entry_t;

   state_e      state_q, state_d;
   logic [7:0]  sweep_q, sweep_d;
   entry_t      mem_q [4];
   entry_t      mem_d [4];
   logic [1:0]  wr_ptr_q, wr_ptr_d;
   logic [1:0]  rd_ptr_q, rd_ptr_d;
   logic [2:0]  occ_q, occ_d;

   logic        fifo_full;
   logic        fifo_empty;
   logic        push;
   logic        pop;
   logic        drop;
   entry_t      head;

   // Only PC[9:2] selects a table entry; the remaining PC bits are ignored.
   logic        pc_unused;
   assign pc_unused = ^{upd_pc[31:10], upd_pc[1:0]};

   // Handshake decode: flush has priority over push and pop.
   always_comb begin
      fifo_full  = (occ_q == 3'd4);
      fifo_empty = (occ_q == 3'd0);
      head       = mem_q[rd_ptr_q];
      upd_ready  = !fifo_full;
      push       = upd_valid && !fifo_full && !flush_req;
      drop       = upd_valid && fifo_full && !flush_req;
      pop        = (state_q == ST_RUN) && !fifo_empty && !flush_req;
   end

   // FIFO next-state: flush empties it; otherwise push at the tail and pop at the head.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (flush_req) begin
         wr_ptr_d = 2'd0;
         rd_ptr_d = 2'd0;
         occ_d    = 3'd0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = '{idx: upd_pc[9:2], target: upd_target,
                                mispredict: upd_mispredict};
            wr_ptr_d = wr_ptr_q + 2'd1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
         end
         occ_d = occ_q + {2'b00, push} - {2'b00, pop};
      end
   end

   // FSM next-state and table-port outputs: the sweep clears entries and RUN drains the FIFO.
   always_comb begin
      state_d        = state_q;
      sweep_d        = sweep_q;
      flush_busy     = 1'b0;
      tbl_we         = 1'b0;
      tbl_clear      = 1'b0;
      tbl_idx        = 8'd0;
      tbl_target     = 32'd0;
      tbl_mispredict = 1'b0;
      dbg_state      = state_q;
      case (state_q)
         ST_SWEEP: begin
            flush_busy = 1'b1;
            tbl_we     = 1'b1;
            tbl_clear  = 1'b1;
            tbl_idx    = sweep_q;
            sweep_d    = sweep_q + 8'd1;
            if (flush_req) begin
               sweep_d = 8'd0;
            end else if (sweep_q == 8'd255) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!fifo_empty) begin
               tbl_we         = 1'b1;
               tbl_idx        = head.idx;
               tbl_target     = head.target;
               tbl_mispredict = head.mispredict;
            end
            if (flush_req) begin
               state_d = ST_SWEEP;
               sweep_d = 8'd0;
            end
         end
         default: begin
            state_d = ST_SWEEP;
            sweep_d = 8'd0;
         end
      endcase
   end

   // State registers: reset starts a fresh sweep with an empty queue.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q  <= ST_SWEEP;
         sweep_q  <= 8'd0;
         wr_ptr_q <= 2'd0;
         rd_ptr_q <= 2'd0;
         occ_q    <= 3'd0;
         for (int i = 0; i < 4; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         sweep_q  <= sweep_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         mem_q    <= mem_d;
      end
   end

`ifdef BP_UPD_STATS_EN
   logic [15:0] stat_upd_q,  stat_upd_d;
   logic [15:0] stat_misp_q, stat_misp_d;
   logic [15:0] stat_drop_q, stat_drop_d;

   // Saturating event counters; flush leaves them alone.
   always_comb begin
      stat_upd_d  = stat_upd_q;
      stat_misp_d = stat_misp_q;
      stat_drop_d = stat_drop_q;
      if (pop && (stat_upd_q != 16'hFFFF)) begin
         stat_upd_d = stat_upd_q + 16'd1;
      end
      if (pop && head.mispredict && (stat_misp_q != 16'hFFFF)) begin
         stat_misp_d = stat_misp_q + 16'd1;
      end
      if (drop && (stat_drop_q != 16'hFFFF)) begin
         stat_drop_d = stat_drop_q + 16'd1;
      end
   end

   // Counter registers, cleared only by reset.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         stat_upd_q  <= 16'd0;
         stat_misp_q <= 16'd0;
         stat_drop_q <= 16'd0;
      end else begin
         stat_upd_q  <= stat_upd_d;
         stat_misp_q <= stat_misp_d;
         stat_drop_q <= stat_drop_d;
      end
   end

   assign stat_upd  = stat_upd_q;
   assign stat_misp = stat_misp_q;
   assign stat_drop = stat_drop_q;
`endif

endmodule

// File: tb/tb_bp_update_sched.sv
// Directed testbench for bp_update_sched. Inputs change 1 time unit after a
// rising edge, and outputs are checked at that same point.
module tb_bp_update_sched;

   logic        clk = 1'b0;
   logic        nrst;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic [31:0] upd_target;
   logic        upd_mispredict;
   logic        upd_ready;
   logic        flush_req;
   logic        flush_busy;
   logic        tbl_we;
   logic [7:0]  tbl_idx;
   logic [31:0] tbl_target;
   logic        tbl_mispredict;
   logic        tbl_clear;
   logic        dbg_state;
`ifdef BP_UPD_STATS_EN
   logic [15:0] stat_upd;
   logic [15:0] stat_misp;
   logic [15:0] stat_drop;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   bp_update_sched dut (
      .CLK            (clk),
      .nRST           (nrst),
      .upd_valid      (upd_valid),
      .upd_pc         (upd_pc),
      .upd_target     (upd_target),
      .upd_mispredict (upd_mispredict),
      .upd_ready      (upd_ready),
      .flush_req      (flush_req),
      .flush_busy     (flush_busy),
      .tbl_we         (tbl_we),
      .tbl_idx        (tbl_idx),
      .tbl_target     (tbl_target),
      .tbl_mispredict (tbl_mispredict),
      .tbl_clear      (tbl_clear),
      .dbg_state      (dbg_state)
`ifdef BP_UPD_STATS_EN
      ,
      .stat_upd       (stat_upd),
      .stat_misp      (stat_misp),
      .stat_drop      (stat_drop)
`endif
   );

   // clock
   always #5 clk = ~clk;

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      upd_valid      = 1'b0;
      upd_pc         = 32'd0;
      upd_target     = 32'd0;
      upd_mispredict = 1'b0;
      flush_req      = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      nrst = 1'b0;
      step();
      nrst = 1'b1;
   endtask

   task automatic drive_upd(input logic [31:0] pc, input logic [31:0] tgt, input logic m);
      upd_valid      = 1'b1;
      upd_pc         = pc;
      upd_target     = tgt;
      upd_mispredict = m;
   endtask

   // Step until flush_busy drops, bounded; returns the number of steps taken or -1.
   task automatic wait_run(output int steps);
      steps = -1;
      for (int k = 0; k < 300; k++) begin
         if (flush_busy === 1'b0) begin
            steps = k;
            break;
         end
         step();
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      n_checks++; if (upd_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", upd_ready); else n_pass++;
      n_checks++; if (flush_busy !== 1'b1) $display("FAIL reset_busy: got %b want 1", flush_busy); else n_pass++;
      n_checks++; if (tbl_we !== 1'b1) $display("FAIL reset_we: got %b want 1", tbl_we); else n_pass++;
      n_checks++; if (tbl_clear !== 1'b1) $display("FAIL reset_clear: got %b want 1", tbl_clear); else n_pass++;
      n_checks++; if (tbl_idx !== 8'd0) $display("FAIL reset_idx: got %h want 00", tbl_idx); else n_pass++;
      n_checks++; if (tbl_target !== 32'd0) $display("FAIL reset_target: got %h want 0", tbl_target); else n_pass++;
      n_checks++; if (tbl_mispredict !== 1'b0) $display("FAIL reset_misp: got %b want 0", tbl_mispredict); else n_pass++;
      n_checks++; if (dbg_state !== 1'b0) $display("FAIL reset_state: got %b want 0", dbg_state); else n_pass++;
`ifdef BP_UPD_STATS_EN
      n_checks++; if ({stat_upd, stat_misp, stat_drop} !== 48'd0)
         $display("FAIL reset_stats: got %h/%h/%h want 0/0/0", stat_upd, stat_misp, stat_drop); else n_pass++;
`endif
   endtask

   task automatic test_sweep();
      int bad = 0;
      int first_bad = -1;
      do_reset();
      for (int i = 0; i < 256; i++) begin
         if (tbl_idx !== i[7:0] || tbl_we !== 1'b1 || tbl_clear !== 1'b1 || flush_busy !== 1'b1 ||
             tbl_target !== 32'd0 || tbl_mispredict !== 1'b0) begin
            bad++;
            if (first_bad < 0) first_bad = i;
         end
         step();
      end
      n_checks++; if (bad !== 0) $display("FAIL sweep_seq: got %0d bad cycles (first at %0d) want 0", bad, first_bad); else n_pass++;
      n_checks++; if (flush_busy !== 1'b0) $display("FAIL sweep_end_busy: got %b want 0", flush_busy); else n_pass++;
      n_checks++; if (tbl_we !== 1'b0) $display("FAIL sweep_end_we: got %b want 0", tbl_we); else n_pass++;
      n_checks++; if ({tbl_idx, tbl_target, tbl_mispredict, tbl_clear} !== 42'd0)
         $display("FAIL run_idle_zero: got idx=%h tgt=%h m=%b c=%b want all 0", tbl_idx, tbl_target, tbl_mispredict, tbl_clear); else n_pass++;
   endtask

   // Assumes RUN with an empty FIFO.
   task automatic test_single();
      drive_upd(32'h0000_0104, 32'h0000_0200, 1'b1);
      step();
      idle_inputs();
      n_checks++; if (tbl_we !== 1'b1) $display("FAIL single_we: got %b want 1", tbl_we); else n_pass++;
      n_checks++; if (tbl_idx !== 8'h41) $display("FAIL single_idx: got %h want 41", tbl_idx); else n_pass++;
      n_checks++; if (tbl_target !== 32'h0000_0200) $display("FAIL single_target: got %h want 00000200", tbl_target); else n_pass++;
      n_checks++; if (tbl_mispredict !== 1'b1) $display("FAIL single_misp: got %b want 1", tbl_mispredict); else n_pass++;
      n_checks++; if (tbl_clear !== 1'b0) $display("FAIL single_clear: got %b want 0", tbl_clear); else n_pass++;
      step();
      n_checks++; if (tbl_we !== 1'b0) $display("FAIL single_retired: got %b want 0", tbl_we); else n_pass++;
   endtask

   // Assumes RUN with an empty FIFO: a push and a pop on the same edge.
   task automatic test_back_to_back();
      logic [7:0]  exp_idx [3] = '{8'h10, 8'h22, 8'hFF};
      logic [31:0] exp_tgt [3] = '{32'h1111_0000, 32'h2222_0004, 32'h3333_0008};
      logic        exp_m   [3] = '{1'b0, 1'b1, 1'b0};
      for (int j = 0; j < 3; j++) begin
         drive_upd({22'h15A, exp_idx[j], 2'b00}, exp_tgt[j], exp_m[j]);
         step();
         if (j > 0) begin
            n_checks++; if (upd_ready !== 1'b1) $display("FAIL b2b_ready_%0d: got %b want 1", j, upd_ready); else n_pass++;
         end
         n_checks++; if (tbl_we !== 1'b1 || tbl_idx !== exp_idx[j] || tbl_target !== exp_tgt[j] || tbl_mispredict !== exp_m[j])
            $display("FAIL b2b_write_%0d: got we=%b idx=%h tgt=%h m=%b want we=1 idx=%h tgt=%h m=%b",
                     j, tbl_we, tbl_idx, tbl_target, tbl_mispredict, exp_idx[j], exp_tgt[j], exp_m[j]); else n_pass++;
      end
      idle_inputs();
      step();
      n_checks++; if (tbl_we !== 1'b0) $display("FAIL b2b_drained: got %b want 0", tbl_we); else n_pass++;
   endtask

   task automatic test_sweep_overflow();
      int steps;
      do_reset();
      for (int j = 0; j < 6; j++) begin
         drive_upd(32'h200 + j * 16, 32'hA000_0000 + j, j[0]);
         n_checks++; if (upd_ready !== (j < 4))
            $display("FAIL ovf_ready_%0d: got %b want %b", j, upd_ready, (j < 4)); else n_pass++;
         step();
      end
      idle_inputs();
      wait_run(steps);
      n_checks++; if (steps < 0) $display("FAIL ovf_sweep_end: got busy=%b after 300 cycles want 0", flush_busy); else n_pass++;
      for (int j = 0; j < 4; j++) begin
         n_checks++; if (tbl_we !== 1'b1 || tbl_clear !== 1'b0 || tbl_idx !== 8'(8'h80 + 4 * j) ||
                         tbl_target !== 32'hA000_0000 + j || tbl_mispredict !== j[0])
            $display("FAIL ovf_write_%0d: got we=%b idx=%h tgt=%h m=%b want we=1 idx=%h tgt=%h m=%b",
                     j, tbl_we, tbl_idx, tbl_target, tbl_mispredict, 8'(8'h80 + 4 * j), 32'hA000_0000 + j, j[0]); else n_pass++;
         step();
      end
      n_checks++; if (tbl_we !== 1'b0) $display("FAIL ovf_no_fifth: got %b want 0", tbl_we); else n_pass++;
`ifdef BP_UPD_STATS_EN
      n_checks++; if (stat_drop !== 16'd2) $display("FAIL ovf_stat_drop: got %0d want 2", stat_drop); else n_pass++;
      n_checks++; if (stat_upd !== 16'd4) $display("FAIL ovf_stat_upd: got %0d want 4", stat_upd); else n_pass++;
      n_checks++; if (stat_misp !== 16'd2) $display("FAIL ovf_stat_misp: got %0d want 2", stat_misp); else n_pass++;
`endif
   endtask

   task automatic test_flush_mid_sweep();
      int bad = 0;
      do_reset();
      repeat (100) step();
      n_checks++; if (tbl_idx !== 8'd100) $display("FAIL fms_at_100: got %0d want 100", tbl_idx); else n_pass++;
      flush_req = 1'b1;
      step();
      flush_req = 1'b0;
      for (int i = 0; i < 256; i++) begin
         if (tbl_idx !== i[7:0] || flush_busy !== 1'b1 || tbl_clear !== 1'b1) bad++;
         step();
      end
      n_checks++; if (bad !== 0) $display("FAIL fms_restart_seq: got %0d bad cycles want 0", bad); else n_pass++;
      n_checks++; if (flush_busy !== 1'b0) $display("FAIL fms_end: got busy=%b want 0", flush_busy); else n_pass++;
   endtask

   task automatic test_flush_discard();
      int steps;
      int writes = 0;
      do_reset();
      drive_upd(32'h0000_0010, 32'h0000_1000, 1'b1);
      step();
      drive_upd(32'h0000_0020, 32'h0000_2000, 1'b0);
      step();
      drive_upd(32'h0000_0030, 32'h0000_3000, 1'b1);
      flush_req = 1'b1;
      step();
      idle_inputs();
      n_checks++; if (tbl_idx !== 8'd0 || flush_busy !== 1'b1)
         $display("FAIL fd_restart: got idx=%h busy=%b want idx=00 busy=1", tbl_idx, flush_busy); else n_pass++;
      wait_run(steps);
      n_checks++; if (steps < 0) $display("FAIL fd_sweep_end: got busy=%b want 0", flush_busy); else n_pass++;
      for (int k = 0; k < 6; k++) begin
         if (tbl_we !== 1'b0) writes++;
         step();
      end
      n_checks++; if (writes !== 0) $display("FAIL fd_no_writes: got %0d writes want 0", writes); else n_pass++;
`ifdef BP_UPD_STATS_EN
      n_checks++; if (stat_upd !== 16'd0) $display("FAIL fd_stat_upd: got %0d want 0", stat_upd); else n_pass++;
`endif
   endtask

   task automatic test_reset_in_run();
      int steps;
      int writes = 0;
      do_reset();
      repeat (253) step();
      for (int j = 0; j < 3; j++) begin
         drive_upd(32'h0000_0400 + j * 4, 32'hC000_0000 + j, 1'b1);
         step();
      end
      idle_inputs();
      n_checks++; if (flush_busy !== 1'b0 || tbl_we !== 1'b1 || tbl_idx !== 8'h00 || tbl_target !== 32'hC000_0000)
         $display("FAIL rr_run_head: got busy=%b we=%b idx=%h tgt=%h want busy=0 we=1 idx=00 tgt=c0000000",
                  flush_busy, tbl_we, tbl_idx, tbl_target); else n_pass++;
      nrst = 1'b0;
      step();
      nrst = 1'b1;
      n_checks++; if (flush_busy !== 1'b1 || tbl_clear !== 1'b1 || tbl_idx !== 8'd0 || upd_ready !== 1'b1)
         $display("FAIL rr_sweep_restart: got busy=%b clr=%b idx=%h rdy=%b want 1 1 00 1",
                  flush_busy, tbl_clear, tbl_idx, upd_ready); else n_pass++;
      wait_run(steps);
      n_checks++; if (steps !== 256) $display("FAIL rr_sweep_len: got %0d want 256", steps); else n_pass++;
      for (int k = 0; k < 6; k++) begin
         if (tbl_we !== 1'b0) writes++;
         step();
      end
      n_checks++; if (writes !== 0) $display("FAIL rr_no_writes: got %0d writes want 0", writes); else n_pass++;
`ifdef BP_UPD_STATS_EN
      n_checks++; if (stat_upd !== 16'd0) $display("FAIL rr_stat_upd: got %0d want 0", stat_upd); else n_pass++;
`endif
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      idle_inputs();
      nrst = 1'b0;
      test_reset();
      test_sweep();
      test_single();
      test_back_to_back();
      test_sweep_overflow();
      test_flush_mid_sweep();
      test_flush_discard();
      test_reset_in_run();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
